// File: rtl/goofy_alu_arb_if.sv
// Requester-side handshake bundle for goofy_alu_arb: two request channels
// plus the shared registered result/flag outputs.
interface goofy_alu_arb_if;
  logic       req0;
  logic [2:0] op0;
  logic [7:0] a0;
  logic [7:0] b0;
  logic       ack0;
  logic       req1;
  logic [2:0] op1;
  logic [7:0] a1;
  logic [7:0] b1;
  logic       ack1;
  logic [7:0] result;
  logic       res_ov;
  logic       res_eq;
  logic       res_err;

  modport master (
    output req0, op0, a0, b0, req1, op1, a1, b1,
    input  ack0, ack1, result, res_ov, res_eq, res_err
  );

  modport slave (
    input  req0, op0, a0, b0, req1, op1, a1, b1,
    output ack0, ack1, result, res_ov, res_eq, res_err
  );
endinterface

// File: rtl/goofy_alu_arb.sv
// Two-requester round-robin front end for an external ALU: latch winner's
// operands, load them, strobe the op, capture result/flags, then ack.
module goofy_alu_arb (
  input  logic            clk,
  input  logic            res,
  goofy_alu_arb_if.slave  bus,
  output logic            alu0w,
  output logic            alu1w,
  output logic [7:0]      alu0d,
  output logic [7:0]      alu1d,
  output logic            alu_add,
  output logic            alu_sub,
  output logic            alu_and,
  output logic            alu_or,
  output logic            alu_not,
  output logic            alu_cmp,
  output logic            alu_flag_res,
  input  logic [7:0]      alu_out_i,
  input  logic            alu_flag_ov_i,
  input  logic            alu_flag_eq_i,
  input  logic            alu_flag_hlt_i
);

  typedef enum logic [1:0] {IDLE, LOAD, EXEC, RESP} state_t;

  state_t     state, state_nxt;
  logic       prio;       // requester that wins a tie
  logic       gnt;        // requester owning the in-flight op
  logic [2:0] op_q;
  logic [7:0] a_q, b_q;
  logic [7:0] result_q;
  logic       ov_q, eq_q, err_q;
  logic       grant, winner, op_legal;

  always_comb begin
    grant    = (state == IDLE) && (bus.req0 || bus.req1) && !alu_flag_hlt_i;
    winner   = (bus.req0 && bus.req1) ? prio : bus.req1;
    op_legal = (op_q <= 3'd5);
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = LOAD;
      LOAD:    state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      prio     <= 1'b0;
      gnt      <= 1'b0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      ov_q     <= 1'b0;
      eq_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (grant) begin
        gnt  <= winner;
        prio <= ~winner;
        op_q <= winner ? bus.op1 : bus.op0;
        a_q  <= winner ? bus.a1  : bus.a0;
        b_q  <= winner ? bus.b1  : bus.b0;
      end
      if (state == EXEC) begin
        // Illegal opcodes report a clean zero result rather than ALU leftovers
        result_q <= op_legal ? alu_out_i     : '0;
        ov_q     <= op_legal ? alu_flag_ov_i : 1'b0;
        eq_q     <= op_legal ? alu_flag_eq_i : 1'b0;
        err_q    <= ~op_legal;
      end
    end
  end

  always_comb begin
    alu0w        = 1'b0;
    alu1w        = 1'b0;
    alu0d        = '0;
    alu1d        = '0;
    alu_flag_res = 1'b0;
    alu_add      = 1'b0;
    alu_sub      = 1'b0;
    alu_and      = 1'b0;
    alu_or       = 1'b0;
    alu_not      = 1'b0;
    alu_cmp      = 1'b0;
    bus.ack0     = 1'b0;
    bus.ack1     = 1'b0;
    case (state)
      LOAD: begin
        alu0w        = 1'b1;
        alu1w        = 1'b1;
        alu0d        = a_q;
        alu1d        = b_q;
        alu_flag_res = 1'b1;
      end
      EXEC: begin
        case (op_q)
          3'd0:    alu_add = 1'b1;
          3'd1:    alu_sub = 1'b1;
          3'd2:    alu_and = 1'b1;
          3'd3:    alu_or  = 1'b1;
          3'd4:    alu_not = 1'b1;
          3'd5:    alu_cmp = 1'b1;
          default: ;
        endcase
      end
      RESP: begin
        bus.ack0 = ~gnt;
        bus.ack1 = gnt;
      end
      default: ;
    endcase
  end

  assign bus.result  = result_q;
  assign bus.res_ov  = ov_q;
  assign bus.res_eq  = eq_q;
  assign bus.res_err = err_q;

endmodule

// File: tb/tb_goofy_alu_arb.sv
// Directed self-checking bench for goofy_alu_arb with a small behavioural ALU.
module tb_goofy_alu_arb;

  logic clk = 1'b0;
  logic res;
  always #5 clk = ~clk;

  goofy_alu_arb_if bus ();

  logic       alu0w, alu1w, alu_flag_res;
  logic [7:0] alu0d, alu1d;
  logic       alu_add, alu_sub, alu_and, alu_or, alu_not, alu_cmp;
  logic [7:0] alu_out_i;
  logic       alu_flag_ov_i, alu_flag_eq_i, hlt;
  logic [5:0] strobes;

  int checks   = 0;
  int failures = 0;
  bit excl_bad = 1'b0;

  goofy_alu_arb dut (
    .clk            (clk),
    .res            (res),
    .bus            (bus),
    .alu0w          (alu0w),
    .alu1w          (alu1w),
    .alu0d          (alu0d),
    .alu1d          (alu1d),
    .alu_add        (alu_add),
    .alu_sub        (alu_sub),
    .alu_and        (alu_and),
    .alu_or         (alu_or),
    .alu_not        (alu_not),
    .alu_cmp        (alu_cmp),
    .alu_flag_res   (alu_flag_res),
    .alu_out_i      (alu_out_i),
    .alu_flag_ov_i  (alu_flag_ov_i),
    .alu_flag_eq_i  (alu_flag_eq_i),
    .alu_flag_hlt_i (hlt)
  );

  assign strobes = {alu_cmp, alu_not, alu_or, alu_and, alu_sub, alu_add};

  // Behavioural ALU; drives garbage when no strobe so illegal ops are visible
  logic [7:0] r0, r1;
  always @(posedge clk) begin
    if (alu0w) r0 <= alu0d;
    if (alu1w) r1 <= alu1d;
  end

  always_comb begin
    alu_out_i     = 8'hA5;
    alu_flag_ov_i = 1'b1;
    alu_flag_eq_i = 1'b1;
    if (alu_add) begin
      {alu_flag_ov_i, alu_out_i} = {1'b0, r0} + {1'b0, r1};
      alu_flag_eq_i = 1'b0;
    end else if (alu_sub) begin
      {alu_flag_ov_i, alu_out_i} = {1'b0, r0} - {1'b0, r1};
      alu_flag_eq_i = 1'b0;
    end else if (alu_and) begin
      alu_out_i = r0 & r1; alu_flag_ov_i = 1'b0; alu_flag_eq_i = 1'b0;
    end else if (alu_or) begin
      alu_out_i = r0 | r1; alu_flag_ov_i = 1'b0; alu_flag_eq_i = 1'b0;
    end else if (alu_not) begin
      alu_out_i = ~r0; alu_flag_ov_i = 1'b0; alu_flag_eq_i = 1'b0;
    end else if (alu_cmp) begin
      alu_out_i = r0 - r1; alu_flag_ov_i = 1'b0; alu_flag_eq_i = (r0 == r1);
    end
  end

  always @(negedge clk) begin
    if ((bus.ack0 && bus.ack1) || ($countones(strobes) > 1)) excl_bad <= 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] strobe_of(input logic [2:0] op);
    return (op <= 3'd5) ? (6'b000001 << op) : 6'b000000;
  endfunction

  task automatic run_op(input bit who, input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] er, input logic eov,
                        input logic eeq, input logic eerr, input bit hlt_mid,
                        input string tag);
    int lat;
    if (!who) begin
      bus.req0 = 1'b1; bus.op0 = op; bus.a0 = a; bus.b0 = b;
    end else begin
      bus.req1 = 1'b1; bus.op1 = op; bus.a1 = a; bus.b1 = b;
    end
    lat = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 1) begin
        chk({tag, "_load_we"}, {alu0w, alu1w, alu_flag_res}, 3'b111);
        chk({tag, "_load_d"}, {alu0d, alu1d}, {a, b});
        if (hlt_mid) hlt = 1'b1;
      end
      if (i == 2) chk({tag, "_strobe"}, strobes, strobe_of(op));
      if (who ? bus.ack1 : bus.ack0) begin
        lat = i;
        break;
      end
    end
    chk({tag, "_latency"}, lat, 3);
    chk({tag, "_other_ack"}, who ? bus.ack0 : bus.ack1, 1'b0);
    chk({tag, "_resp_quiet"}, {strobes, alu0w, alu1w}, 8'h00);
    chk({tag, "_result"}, {bus.res_err, bus.res_eq, bus.res_ov, bus.result},
        {eerr, eeq, eov, er});
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    hlt      = 1'b0;
    tick();
    chk({tag, "_ack_pulse"}, {bus.ack0, bus.ack1}, 2'b00);
    chk({tag, "_hold"}, {bus.res_err, bus.res_eq, bus.res_ov, bus.result},
        {eerr, eeq, eov, er});
  endtask

  initial begin
    int        n;
    bit        saw_load;
    bit        order [4];
    logic [7:0] rres [4];

    res = 1'b0; hlt = 1'b0;
    bus.req0 = 1'b0; bus.op0 = '0; bus.a0 = '0; bus.b0 = '0;
    bus.req1 = 1'b0; bus.op1 = '0; bus.a1 = '0; bus.b1 = '0;
    #2;
    chk("reset_handshake", {bus.ack0, bus.ack1, bus.res_err, bus.res_eq, bus.res_ov, bus.result},
        13'h0);
    chk("reset_alu_ctl", {alu0w, alu1w, alu_flag_res, strobes, alu0d, alu1d}, 25'h0);
    @(negedge clk); res = 1'b1;
    tick();

    run_op(0, 3'd0, 8'h0F, 8'h01, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0, "add0f");
    run_op(0, 3'd0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, "addff");
    run_op(0, 3'd0, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, "add11");
    run_op(1, 3'd1, 8'h30, 8'h10, 8'h20, 1'b0, 1'b0, 1'b0, 1'b0, "sub1");
    run_op(1, 3'd1, 8'h01, 8'h02, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, "subbor");
    run_op(0, 3'd2, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0, "and");
    run_op(1, 3'd3, 8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, "or");
    run_op(0, 3'd4, 8'h0F, 8'h00, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, "not");
    run_op(1, 3'd5, 8'h5A, 8'h5A, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, "cmp");
    run_op(0, 3'd7, 8'h12, 8'h34, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, "illegal");
    run_op(0, 3'd0, 8'h20, 8'h22, 8'h42, 1'b0, 1'b0, 1'b0, 1'b1, "hltmid");

    // Both requesters held from reset: expect 0,1,0,1
    res = 1'b0;
    bus.req0 = 1'b1; bus.op0 = 3'd0; bus.a0 = 8'h01; bus.b0 = 8'h02;
    bus.req1 = 1'b1; bus.op1 = 3'd3; bus.a1 = 8'h0C; bus.b1 = 8'h30;
    @(negedge clk); res = 1'b1;
    tick();
    n = 0;
    for (int i = 0; i < 40 && n < 4; i++) begin
      if (bus.ack0 || bus.ack1) begin
        order[n] = bus.ack1;
        rres[n]  = bus.result;
        n++;
      end
      tick();
    end
    chk("rr_count", n, 4);
    chk("rr_order", {order[0], order[1], order[2], order[3]}, 4'b0101);
    chk("rr_results", {rres[0], rres[1], rres[2], rres[3]}, 32'h033C_033C);
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    repeat (4) tick();

    // Halt blocks grants while a request is held
    hlt = 1'b1;
    bus.req0 = 1'b1; bus.op0 = 3'd0; bus.a0 = 8'h03; bus.b0 = 8'h04;
    saw_load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (alu0w || alu1w || (strobes != 6'b0) || bus.ack0) saw_load = 1'b1;
    end
    chk("hlt_blocks", saw_load, 1'b0);
    hlt = 1'b0;
    run_op(0, 3'd0, 8'h03, 8'h04, 8'h07, 1'b0, 1'b0, 1'b0, 1'b0, "hltrel");

    // Reset asserted mid-EXEC discards the op
    bus.req0 = 1'b1; bus.op0 = 3'd0; bus.a0 = 8'h0F; bus.b0 = 8'h01;
    tick();
    tick();
    chk("rst_pre_exec", strobes, 6'b000001);
    res = 1'b0;
    #1;
    chk("rst_async_outs", {bus.ack0, bus.ack1, bus.res_err, bus.res_eq, bus.res_ov, bus.result,
                           strobes, alu0w, alu1w, alu_flag_res}, 22'h0);
    bus.req0 = 1'b0;
    saw_load = 1'b0;
    repeat (3) begin
      tick();
      if (bus.ack0 || bus.ack1) saw_load = 1'b1;
    end
    chk("rst_no_ack", saw_load, 1'b0);
    @(negedge clk); res = 1'b1;
    tick();
    run_op(1, 3'd1, 8'h10, 8'h01, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, "postrst");

    chk("exclusive", excl_bad, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
